// File: rtl/cv_dac_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cv_dac_ramp_ctrl_pkg
//  Description : Shared definitions for the CV-loop DAC ramp controller.
//                Holds the ramp state encodings and the default field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package cv_dac_ramp_ctrl_pkg;

    // Default field widths
    localparam int C_CVR_DAC_W  = 10;
    localparam int C_CVR_STEP_W = 4;
    localparam int C_CVR_INTV_W = 8;

    // Ramp sequencer states
    typedef enum logic [1:0] {
        CVR_IDLE = 2'd0,
        CVR_UP   = 2'd1,
        CVR_DN   = 2'd2,
        CVR_HOLD = 2'd3
    } cvr_state_e;

endpackage : cv_dac_ramp_ctrl_pkg
`default_nettype wire

// File: rtl/cv_dac_ramp_ctrl_tick.sv
`default_nettype none
// ============================================================================
//  Module      : cv_ramp_tick
//  Description : Step-interval down-counter. o_tick is high while the count
//                is zero; i_load (priority) reloads it, i_dec counts it down
//                and it parks at zero until reloaded.
//  Ports       : clk, rstz      - clock, async active-low reset
//                i_load, i_val  - reload strobe and reload value
//                i_dec          - decrement enable
//                o_tick         - count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module cv_ramp_tick #(
    parameter int INTV_W = 8
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              i_load,
    input  logic              i_dec,
    input  logic [INTV_W-1:0] i_val,
    output logic              o_tick
);

    logic [INTV_W-1:0] cnt_q;
    logic [INTV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);

endmodule : cv_ramp_tick
`default_nettype wire

// File: rtl/cv_dac_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cv_dac_ramp_ctrl
//  Description : Slew-limited sequencer for the CV-loop DAC code. Moves o_dac
//                from its current value to a new target in steps of i_step
//                codes every i_intv+1 cycles, drives VO discharge on down
//                ramps and freezes in HOLD on protection faults.
//  Ports       : clk, rstz          - clock, async active-low reset
//                i_en               - block enable (0 -> IDLE, code frozen)
//                i_tgt, i_tgt_vld   - target code and load/retarget pulse
//                i_step, i_intv     - codes per step, cycles per step - 1
//                i_fault            - protection fault level
//                o_dac              - DAC code
//                o_busy, o_dischg   - ramping, discharging (down ramp)
//                o_done, o_hold     - target reached pulse, fault hold
//  Revision    : 1.0 - initial release
// ============================================================================
module cv_dac_ramp_ctrl
    import cv_dac_ramp_ctrl_pkg::*;
#(
    parameter int               DAC_W   = C_CVR_DAC_W,
    parameter int               STEP_W  = C_CVR_STEP_W,
    parameter int               INTV_W  = C_CVR_INTV_W,
    parameter logic [DAC_W-1:0] DAC_RST = '0
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              i_en,
    input  logic [DAC_W-1:0]  i_tgt,
    input  logic              i_tgt_vld,
    input  logic [STEP_W-1:0] i_step,
    input  logic [INTV_W-1:0] i_intv,
    input  logic              i_fault,
    output logic [DAC_W-1:0]  o_dac,
    output logic              o_busy,
    output logic              o_dischg,
    output logic              o_done,
    output logic              o_hold
);

    cvr_state_e       state_q, state_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic [DAC_W-1:0] tgt_q, tgt_d;
    logic             done_q, done_d;
    logic             busy_q, dischg_q, hold_q;

    logic             w_tick;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [DAC_W:0]   w_step_ext;
    logic [DAC_W:0]   w_sum;
    logic [DAC_W:0]   w_diff;
    logic [DAC_W-1:0] w_up_val;
    logic [DAC_W-1:0] w_dn_val;
    logic [DAC_W-1:0] w_nxt;

    // Step interval counter; reloaded from the live i_intv on start and on
    // every step tick so rate changes apply from the next step onward.
    cv_ramp_tick #(
        .INTV_W (INTV_W)
    ) u_tick (
        .clk    (clk),
        .rstz   (rstz),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .i_val  (i_intv),
        .o_tick (w_tick)
    );

    // One extra bit of headroom so neither direction can wrap before the
    // clamp against the target is applied.
    assign w_step_ext = (i_step == '0) ? {{DAC_W{1'b0}}, 1'b1}
                                       : {{(DAC_W + 1 - STEP_W){1'b0}}, i_step};
    assign w_sum      = {1'b0, dac_q} + w_step_ext;
    assign w_diff     = {1'b0, dac_q} - w_step_ext;
    assign w_up_val   = (w_sum > {1'b0, tgt_q}) ? tgt_q : w_sum[DAC_W-1:0];
    assign w_dn_val   = (w_diff[DAC_W] || (w_diff[DAC_W-1:0] < tgt_q)) ? tgt_q
                                                                       : w_diff[DAC_W-1:0];

    always_comb begin
        state_d    = state_q;
        dac_d      = dac_q;
        tgt_d      = tgt_q;
        done_d     = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_nxt      = dac_q;

        if (!i_en) begin
            state_d = CVR_IDLE;
        end else if (i_fault) begin
            // Fault outranks any load/retarget and suppresses this edge's step.
            state_d = CVR_HOLD;
        end else begin
            case (state_q)
                CVR_IDLE: begin
                    if (i_tgt_vld) begin
                        tgt_d      = i_tgt;
                        w_cnt_load = 1'b1;
                        if (i_tgt > dac_q) begin
                            state_d = CVR_UP;
                        end else if (i_tgt < dac_q) begin
                            state_d = CVR_DN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                CVR_UP, CVR_DN: begin
                    // The interval counter keeps running through a retarget;
                    // a retarget edge itself applies no step.
                    w_cnt_dec  = 1'b1;
                    w_cnt_load = w_tick;
                    if (i_tgt_vld) begin
                        tgt_d = i_tgt;
                        if (i_tgt > dac_q) begin
                            state_d = CVR_UP;
                        end else if (i_tgt < dac_q) begin
                            state_d = CVR_DN;
                        end else begin
                            state_d = CVR_IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (w_tick) begin
                        w_nxt = (state_q == CVR_UP) ? w_up_val : w_dn_val;
                        dac_d = w_nxt;
                        if (w_nxt == tgt_q) begin
                            state_d = CVR_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                CVR_HOLD: begin
                    // The releasing pulse only re-arms; it does not start a ramp.
                    if (i_tgt_vld) begin
                        state_d = CVR_IDLE;
                    end
                end
                default: begin
                    state_d = CVR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q  <= CVR_IDLE;
            dac_q    <= DAC_RST;
            tgt_q    <= DAC_RST;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dischg_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            tgt_q    <= tgt_d;
            done_q   <= done_d;
            busy_q   <= (state_d == CVR_UP) || (state_d == CVR_DN);
            dischg_q <= (state_d == CVR_DN);
            hold_q   <= (state_d == CVR_HOLD);
        end
    end

    assign o_dac    = dac_q;
    assign o_busy   = busy_q;
    assign o_dischg = dischg_q;
    assign o_done   = done_q;
    assign o_hold   = hold_q;

endmodule : cv_dac_ramp_ctrl
`default_nettype wire

// File: tb/tb_cv_dac_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cv_dac_ramp_ctrl
//  Description : Self-checking bench for cv_dac_ramp_ctrl: a table of ramp
//                vectors plus directed sequences for saturation, retarget,
//                fault hold, enable drop and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cv_dac_ramp_ctrl;

    logic       clk;
    logic       rstz;
    logic       i_en;
    logic [9:0] i_tgt;
    logic       i_tgt_vld;
    logic [3:0] i_step;
    logic [7:0] i_intv;
    logic       i_fault;
    logic [9:0] o_dac;
    logic       o_busy;
    logic       o_dischg;
    logic       o_done;
    logic       o_hold;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [9:0] tgt;
        logic [3:0] step;
        logic [7:0] intv;
        logic [9:0] exp_dac;
        int         exp_lat;
        logic       exp_dischg;
    } vec_t;

    vec_t vecs[8];

    cv_dac_ramp_ctrl u_dut (
        .clk       (clk),
        .rstz      (rstz),
        .i_en      (i_en),
        .i_tgt     (i_tgt),
        .i_tgt_vld (i_tgt_vld),
        .i_step    (i_step),
        .i_intv    (i_intv),
        .i_fault   (i_fault),
        .o_dac     (o_dac),
        .o_busy    (o_busy),
        .o_dischg  (o_dischg),
        .o_done    (o_done),
        .o_hold    (o_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse i_tgt_vld for one edge; returns at the negedge after that edge.
    task automatic pulse(input logic [9:0] tgt, input logic [3:0] step, input logic [7:0] intv);
        @(negedge clk);
        i_tgt     = tgt;
        i_step    = step;
        i_intv    = intv;
        i_tgt_vld = 1'b1;
        @(negedge clk);
        i_tgt_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int bad;
        pulse(v.tgt, v.step, v.intv);
        n   = 0;
        bad = 0;
        while (!o_done && n < 2000) begin
            if (o_busy !== 1'b1 || o_dischg !== v.exp_dischg) bad = 1;
            @(negedge clk);
            n++;
        end
        chk({v.name, "_latency"}, n, v.exp_lat);
        chk({v.name, "_dac"}, int'(o_dac), int'(v.exp_dac));
        chk({v.name, "_flags_during"}, bad, 0);
        chk({v.name, "_busy_dischg_after"}, int'({o_busy, o_dischg}), 0);
        @(negedge clk);
        chk({v.name, "_done_width"}, int'(o_done), 0);
    endtask

    initial begin
        int   n;
        int   ndone;
        logic [9:0] d0;
        vec_t v;

        // name, tgt, step, intv, exp_dac, exp_lat, exp_dischg
        vecs[0] = '{"dn_sat",    10'd0,    4'd15, 8'd0, 10'd0,    1,   1'b1};
        vecs[1] = '{"up_slow",   10'd100,  4'd4,  8'd9, 10'd100,  250, 1'b0};
        vecs[2] = '{"up_clamp",  10'd200,  4'd15, 8'd2, 10'd200,  21,  1'b0};
        vecs[3] = '{"dn_step0",  10'd120,  4'd0,  8'd1, 10'd120,  160, 1'b1};
        vecs[4] = '{"equal",     10'd120,  4'd5,  8'd3, 10'd120,  0,   1'b0};
        vecs[5] = '{"up_top",    10'd1023, 4'd15, 8'd0, 10'd1023, 61,  1'b0};
        vecs[6] = '{"dn_clamp",  10'd1020, 4'd15, 8'd0, 10'd1020, 1,   1'b1};
        vecs[7] = '{"dn_zero",   10'd0,    4'd15, 8'd0, 10'd0,    68,  1'b1};

        rstz      = 1'b0;
        i_en      = 1'b1;
        i_tgt     = '0;
        i_tgt_vld = 1'b0;
        i_step    = '0;
        i_intv    = '0;
        i_fault   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dac", int'(o_dac), 0);
        chk("reset_flags", int'({o_busy, o_dischg, o_done, o_hold}), 0);
        rstz = 1'b1;

        // Saturating up-ramp 0 -> 10, one step per cycle
        pulse(10'd10, 4'd4, 8'd0);
        chk("sat_e0_dac", int'(o_dac), 0);
        chk("sat_e0_busy", int'(o_busy), 1);
        @(negedge clk); chk("sat_s1", int'(o_dac), 4);
        @(negedge clk); chk("sat_s2", int'(o_dac), 8);
        @(negedge clk); chk("sat_s3", int'(o_dac), 10);
        chk("sat_done", int'(o_done), 1);
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Retarget 0 -> 100 step 2, redirected to 20 once o_dac reaches 40
        pulse(10'd100, 4'd2, 8'd3);
        n = 0;
        ndone = 0;
        while (o_dac != 10'd40 && n < 500) begin
            if (o_done) ndone++;
            @(negedge clk);
            n++;
        end
        chk("rt_reach40", int'(o_dac), 40);
        i_tgt     = 10'd20;
        i_tgt_vld = 1'b1;
        @(negedge clk);
        i_tgt_vld = 1'b0;
        chk("rt_dir_dn", int'({o_busy, o_dischg}), 3);
        chk("rt_dac_hold", int'(o_dac), 40);
        n = 0;
        while (!o_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rt_latency", n, 39);
        chk("rt_final", int'(o_dac), 20);
        ndone++;
        repeat (10) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("rt_one_done", ndone, 1);

        // Fault mid up-ramp at o_dac = 50
        pulse(10'd100, 4'd2, 8'd0);
        n = 0;
        while (o_dac != 10'd50 && n < 500) begin
            @(negedge clk);
            n++;
        end
        i_fault = 1'b1;
        @(negedge clk);
        chk("flt_hold", int'(o_hold), 1);
        chk("flt_dac", int'(o_dac), 50);
        chk("flt_busy_dischg", int'({o_busy, o_dischg}), 0);
        pulse(10'd0, 4'd2, 8'd0);
        repeat (2) @(negedge clk);
        chk("flt_wins", int'({o_hold, o_dac}), int'({1'b1, 10'd50}));
        i_fault = 1'b0;
        pulse(10'd0, 4'd2, 8'd0);
        chk("flt_exit", int'({o_hold, o_busy, o_done}), 0);
        repeat (2) @(negedge clk);
        chk("flt_no_ramp", int'(o_dac), 50);
        v = '{"post_flt", 10'd60, 4'd4, 8'd0, 10'd60, 3, 1'b0};
        run_vec(v);

        // Enable drop mid-ramp freezes the code
        pulse(10'd200, 4'd1, 8'd0);
        repeat (5) @(negedge clk);
        d0   = o_dac;
        i_en = 1'b0;
        @(negedge clk);
        chk("en_busy", int'(o_busy), 0);
        chk("en_frozen", int'(o_dac), int'(d0));
        chk("en_mid", int'(d0), 65);
        pulse(10'd300, 4'd1, 8'd0);
        repeat (2) @(negedge clk);
        chk("en_ignored", int'({o_busy, o_done, o_dac}), int'({2'b00, d0}));
        i_en = 1'b1;

        // Asynchronous reset mid-ramp
        pulse(10'd300, 4'd1, 8'd0);
        repeat (4) @(negedge clk);
        #3 rstz = 1'b0;
        #1;
        chk("arst_dac", int'(o_dac), 0);
        chk("arst_busy", int'(o_busy), 0);
        @(negedge clk);
        rstz = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_idle", int'({o_busy, o_dac}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cv_dac_ramp_ctrl
`default_nettype wire
